// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared constants for the unified data-memory arbiter:
//   - WORD_W          : memory word / address width (16)
//   - IDLE..HALTED    : arbiter FSM state encoding (3-bit, legacy-compatible)
//   - REQ_IF / REQ_D  : requester IDs, also the encoding of the grant and
//                       round-robin last-grant registers
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int WORD_W = 16;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCESS = 3'd1;
   localparam logic [2:0] DONE   = 3'd2;
   localparam logic [2:0] DUMP   = 3'd3;
   localparam logic [2:0] HALTED = 3'd4;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/dmem_lat_timer.sv
// -----------------------------------------------------------------------------
// dmem_lat_timer
// Down-counter that times how long the memory pins are held for one access.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   load_i   in   start a new access (loads LAT-1)
//   run_i    in   an access is in progress (counter decrements)
//   expire_o out  high during the last cycle of the access
// -----------------------------------------------------------------------------
module dmem_lat_timer #(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counting LAT-1 down to 0 gives exactly LAT cycles with run_i high.
   assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the fetch port and the data
// (load/store) port, holds each access on the memory pins for MEM_LAT cycles,
// and sequences the halt -> dump -> halted shutdown.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration between the
// two ports (simultaneous requests alternate, data first after reset).
// Without it, the data port always wins over fetch.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_done/if_stall    fetch read data, completion pulse, stall
//   d_rd/d_wr/d_addr/d_wdata     data-port load/store request, addr, data
//   d_rdata/d_done/d_stall       load data, completion pulse, stall
//   halt                         stop granting, then dump memory
//   mem_en/mem_wr/mem_addr/mem_din/mem_dout/mem_dump   memory pins
//   err                          sticky: load and store requested together
//   dbg_state                    current FSM state (IDLE..HALTED)
//
// Handshake: a requester raises its request with stable address/data and
// holds them until its done pulse; done is high for exactly one cycle and
// the matching stall is request & ~done. A request still high during the
// done cycle is taken as a new request.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [WORD_W-1:0] if_addr,
   output logic [WORD_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   input  logic              halt,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_din,
   input  logic [WORD_W-1:0] mem_dout,
   output logic              mem_dump,
   output logic              err,
   output logic [2:0]        dbg_state
);

   logic [2:0]        state_q, state_d;
   logic              gnt_q;
   logic              mem_en_q, mem_wr_q;
   logic [WORD_W-1:0] mem_addr_q, mem_din_q;
   logic [WORD_W-1:0] if_rdata_q, d_rdata_q;
   logic              err_q;

   logic d_req, any_req, grant, sel, expire;

   assign d_req   = d_rd | d_wr;
   assign any_req = d_req | if_req;

   // A grant can be issued from IDLE or at the exit of DONE, so back-to-back
   // accesses run without an idle cycle.
   assign grant = ((state_q == IDLE) || (state_q == DONE)) && !halt && any_req;

`ifdef DMEM_ARB_RR_EN
   logic last_q;

   always_comb begin
      sel = d_req ? REQ_D : REQ_IF;
      if (d_req && if_req) begin
         sel = (last_q == REQ_D) ? REQ_IF : REQ_D;
      end
   end

   // Reset to REQ_IF so the first contested grant goes to the data port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= REQ_IF;
      end else if (grant) begin
         last_q <= sel;
      end
   end
`else
   always_comb begin
      sel = d_req ? REQ_D : REQ_IF;
   end
`endif

   dmem_lat_timer #(
      .LAT (MEM_LAT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (grant),
      .run_i    (state_q == ACCESS),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (halt) begin
               state_d = DUMP;
            end else if (any_req) begin
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS:  state_d = expire ? DONE : ACCESS;
         DUMP:    state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= REQ_IF;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            gnt_q    <= sel;
            mem_en_q <= 1'b1;
            if (sel == REQ_D) begin
               // A combined load+store is performed as the store.
               mem_wr_q   <= d_wr;
               mem_addr_q <= d_addr;
               mem_din_q  <= d_wdata;
               if (d_rd && d_wr) begin
                  err_q <= 1'b1;
               end
            end else begin
               mem_wr_q   <= 1'b0;
               mem_addr_q <= if_addr;
               mem_din_q  <= '0;
            end
         end else if (expire) begin
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (!mem_wr_q) begin
               if (gnt_q == REQ_D) begin
                  d_rdata_q <= mem_dout;
               end else begin
                  if_rdata_q <= mem_dout;
               end
            end
         end
      end
   end

   assign if_done   = (state_q == DONE) && (gnt_q == REQ_IF);
   assign d_done    = (state_q == DONE) && (gnt_q == REQ_D);
   assign if_stall  = if_req & ~if_done;
   assign d_stall   = d_req & ~d_done;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign mem_dump  = (state_q == DUMP);
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule
